fetch_unit: RTL and testbench

- Multi-cycle instruction fetch stage that sits directly upstream of the core controller/decoder.
- Owns the PC register and drives a req/ack instruction-memory handshake.
- Presents a held instruction word (op, funct3 and funct7b5 fields) to decode.
- Computes the next PC from the PCSrc/Jalr decisions and targets returned by the execute path.

---
 rtl/fetch_unit.sv | 64 ++++++
 tb/tb_fetch_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch stage owning the PC and the imem req/ack handshake
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ack,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               pc_src,
  input  logic               jalr,
  input  logic [31:0]        branch_target,
  input  logic [31:0]        alu_result,
  output logic               fault,
  output logic [COUNT_W-1:0] retired
);
  typedef enum logic [1:0] {RESET_WAIT, FETCH, HOLD, FAULT} state_t;
  state_t state, state_n;
  logic [31:0] next_pc;
  logic capture, accept;
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign capture   = state == FETCH && imem_ack;
  assign accept    = state == HOLD && instr_ready;
  assign next_pc   = jalr ? (alu_result & ~32'h1) : pc_src ? branch_target : pc_plus4;
  // State register; reset parks the FSM until the first clean edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RESET_WAIT;
    else state <= state_n;
  // Next state and request strobe; a target with bit 1 set traps permanently
  always_comb begin
    imem_req = state == FETCH;
    state_n  = state == RESET_WAIT ? FETCH :
               capture             ? HOLD :
               accept              ? (next_pc[1] ? FAULT : FETCH) : state;
  end
  // PC, held instruction, fault flag and retire counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= 32'h0000_0013;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      retired     <= '0;
    end else begin
      if (capture) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (accept) begin
        retired     <= retired + COUNT_W'(1);
        instr_valid <= 1'b0;
        if (next_pc[1]) fault <= 1'b1;
        else pc <= next_pc;
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a per-cycle behavioural model of the fetch stage
module tb_fetch_unit;
  logic clk = 0, reset;
  logic imem_req, imem_ack = 0, instr_valid, instr_ready = 0, pc_src = 0, jalr = 0, fault;
  logic [31:0] imem_addr, imem_rdata = 0, instr, pc, pc_plus4, branch_target = 0, alu_result = 0;
  logic [2:0] retired;
  int tests = 0, fails = 0;
  fetch_unit #(.RESET_PC(32'h0), .COUNT_W(3)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .pc_plus4(pc_plus4), .pc_src(pc_src), .jalr(jalr),
    .branch_target(branch_target), .alu_result(alu_result), .fault(fault), .retired(retired));
  always #5 clk = ~clk;
  // model: running = out of reset wait, valid = holding an instruction, fault = trapped
  bit m_run = 0, m_valid = 0, m_fault = 0;
  logic [31:0] m_pc = 0, m_instr = 32'h13, tgt;
  int m_ret = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_valid = 0; m_fault = 0; m_pc = 0; m_instr = 32'h13; m_ret = 0;
    end else if (!m_run) m_run = 1;
    else if (!m_fault) begin
      if (!m_valid && imem_ack) begin
        m_instr = imem_rdata; m_valid = 1;
      end else if (m_valid && instr_ready) begin
        m_ret = (m_ret + 1) % 8;
        tgt = jalr ? {alu_result[31:1], 1'b0} : pc_src ? branch_target : m_pc + 32'd4;
        m_valid = 0;
        if (tgt[1]) m_fault = 1;
        else m_pc = tgt;
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("req", 32'(imem_req), 32'(m_run && !m_valid && !m_fault));
    chk("addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("valid", 32'(instr_valid), 32'(m_valid));
    chk("instr", instr, m_instr);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("retired", 32'(retired), 32'(m_ret));
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic fetch(input logic [31:0] w, input int waits);
    repeat (waits) step();
    imem_ack = 1; imem_rdata = w;
    step();
    imem_ack = 0; imem_rdata = 0;
  endtask
  task automatic accept(input logic s, input logic j, input logic [31:0] bt, input logic [31:0] alu);
    instr_ready = 1; pc_src = s; jalr = j; branch_target = bt; alu_result = alu;
    step();
    instr_ready = 0; pc_src = 0; jalr = 0;
  endtask
  initial begin
    reset = 0;
    repeat (2) step();
    chk("lit_reset_instr", instr, 32'h13);
    chk("lit_reset_req", 32'(imem_req), 0);
    reset = 1;
    step();
    chk("lit_first_req", 32'(imem_req), 1);
    chk("lit_first_addr", imem_addr, 32'h0);
    fetch(32'h00500093, 1);
    chk("lit_instr0", instr, 32'h00500093);
    chk("lit_valid0", 32'(instr_valid), 1);
    step();
    accept(0, 0, 0, 0);
    chk("lit_addr4", imem_addr, 32'h4);
    fetch(32'h00A00113, 1);
    chk("lit_instr1", instr, 32'h00A00113);
    step();
    accept(0, 0, 0, 0);
    chk("lit_addr8", imem_addr, 32'h8);
    chk("lit_retired2", 32'(retired), 2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_wait_req", 32'(imem_req), 1);
      chk("lit_wait_valid", 32'(instr_valid), 0);
    end
    fetch(32'h11111111, 0);
    imem_ack = 1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack = 0;
    chk("lit_spurious_ack", instr, 32'h11111111);
    accept(0, 0, 0, 0);
    fetch(32'h22222222, 0);
    accept(0, 0, 0, 0);
    chk("lit_addr10", imem_addr, 32'h10);
    fetch(32'h33333333, 1);
    accept(1, 0, 32'h40, 0);
    chk("lit_branch", imem_addr, 32'h40);
    fetch(32'h44444444, 0);
    accept(1, 0, 32'h10, 0);
    fetch(32'h55555555, 0);
    chk("lit_plus4_10", pc_plus4, 32'h14);
    accept(0, 0, 32'h40, 0);
    chk("lit_not_taken", imem_addr, 32'h14);
    fetch(32'h66666666, 0);
    chk("lit_plus4_14", pc_plus4, 32'h18);
    accept(1, 1, 32'h80, 32'h101);
    chk("lit_jalr", imem_addr, 32'h100);
    fetch(32'h77777777, 2);
    accept(1, 0, 32'hFFFF_FFFC, 0);
    chk("lit_top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("lit_retired_wrap", 32'(retired), 1);
    fetch(32'h88888888, 0);
    chk("lit_plus4_wrap", pc_plus4, 32'h0);
    accept(0, 0, 0, 0);
    chk("lit_pc_wrap", imem_addr, 32'h0);
    chk("lit_retired2b", 32'(retired), 2);
    fetch(32'h99999999, 0);
    accept(1, 0, 32'h42, 0);
    chk("lit_fault", 32'(fault), 1);
    chk("lit_fault_pc", pc, 32'h0);
    instr_ready = 1; imem_ack = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lit_fault_req", 32'(imem_req), 0);
      chk("lit_fault_valid", 32'(instr_valid), 0);
    end
    instr_ready = 0; imem_ack = 0;
    #3 reset = 0;
    #1;
    chk("lit_async_fault", 32'(fault), 0);
    chk("lit_async_retired", 32'(retired), 0);
    chk("lit_async_instr", instr, 32'h13);
    step();
    reset = 1;
    step();
    imem_ack = 1; imem_rdata = 32'hCAFEF00D;
    #3 reset = 0;
    step();
    imem_ack = 0;
    chk("lit_ack_dropped", instr, 32'h13);
    chk("lit_ack_dropped_v", 32'(instr_valid), 0);
    reset = 1;
    step();
    chk("lit_restart_addr", imem_addr, 32'h0);
    chk("lit_restart_req", 32'(imem_req), 1);
    fetch(32'hABCD0013, 1);
    chk("lit_restart_instr", instr, 32'hABCD0013);
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
